// File: rtl/robot_cmd_player.sv
// Plays stored 2-bit direction commands onto HEX0-HEX3/LEDR, one per STEP_TICKS,
// with an optional blank gap between commands, and flags done after the last one.
module robot_cmd_player #(
    parameter int ADDR_W     = 8,
    parameter int STEP_TICKS = 50_000_000,
    parameter int GAP_TICKS  = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   cmd_count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_index,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [17:0]       LEDR
);
    localparam int TMAX = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]     STEP_LD = TW'(STEP_TICKS - 1);
    localparam logic [TW-1:0]     GAP_LD  = (GAP_TICKS > 0) ? TW'(GAP_TICKS - 1) : '0;
    localparam logic [TW-1:0]     T_ONE   = TW'(1);
    localparam logic [ADDR_W-1:0] I_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   N_ONE   = (ADDR_W + 1)'(1);
    // {HEX3, HEX2, HEX1, HEX0, LEDR}
    localparam logic [45:0]       BLANK   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 18'h0};

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, RUN, GAP, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   n_reg;
    logic [ADDR_W-1:0] idx;
    logic [TW-1:0]     timer;
    logic [45:0]       disp;
    logic              last;

    function automatic logic [45:0] decode(input logic [1:0] c);
        case (c)
            2'b00:   return {7'h7F, 7'b0001110, 7'h7F, 7'h7F, 18'h00F0F};
            2'b01:   return {7'h7F, 7'h7F, 7'h7F, 7'b0101111, 18'h00F0C};
            2'b10:   return {7'h7F, 7'h7F, 7'b1000111, 7'h7F, 18'h00C0F};
            default: return {7'b0000011, 7'h7F, 7'h7F, 7'h7F, 18'h0F0F0};
        endcase
    endfunction

    // Compared in ADDR_W+1 bits so a full memory (n_reg = 2^ADDR_W) ends without idx wrapping.
    assign last = ({1'b0, idx} == n_reg - N_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nx = (cmd_count == '0) ? DONE : FETCH;
                FETCH:      state_nx = LOAD;
                LOAD:       state_nx = RUN;
                RUN:        if (timer == '0) state_nx = last ? DONE : ((GAP_TICKS > 0) ? GAP : FETCH);
                GAP:        if (timer == '0) state_nx = FETCH;
                default:    state_nx = IDLE;
            endcase
        end
    end

    // rd_addr is updated on entry to FETCH so the synchronous memory answers during LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg     <= '0;
            idx       <= '0;
            timer     <= '0;
            rd_addr   <= '0;
            cur_index <= '0;
            disp      <= BLANK;
        end else if (abort) begin
            timer <= '0;
            disp  <= BLANK;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    n_reg   <= cmd_count;
                    idx     <= '0;
                    rd_addr <= '0;
                    disp    <= BLANK;
                end
                LOAD: begin
                    cur_index <= idx;
                    timer     <= STEP_LD;
                    disp      <= decode(rd_data);
                end
                RUN: begin
                    if (timer != '0) begin
                        timer <= timer - T_ONE;
                    end else if (!last) begin
                        if (GAP_TICKS > 0) begin
                            timer <= GAP_LD;
                            disp  <= BLANK;
                        end else begin
                            idx     <= idx + I_ONE;
                            rd_addr <= idx + I_ONE;
                        end
                    end
                end
                GAP: begin
                    if (timer != '0) begin
                        timer <= timer - T_ONE;
                    end else begin
                        idx     <= idx + I_ONE;
                        rd_addr <= idx + I_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state == FETCH) || (state == LOAD) || (state == RUN) || (state == GAP);
        done = (state == DONE);
    end

    assign {HEX3, HEX2, HEX1, HEX0, LEDR} = disp;

endmodule

// File: tb/tb_robot_cmd_player.sv
// Directed bench for robot_cmd_player: STEP_TICKS=4 with GAP_TICKS=2 and a GAP_TICKS=0 build.
module tb_robot_cmd_player;
    localparam int ADDR_W = 8;
    localparam logic [45:0] BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 18'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              start = 1'b0, abort = 1'b0;
    logic [ADDR_W:0]   cmd_count = '0;
    logic [ADDR_W-1:0] rd_addr, cur_index;
    logic [1:0]        rd_data;
    logic              busy, done;
    logic [6:0]        HEX0, HEX1, HEX2, HEX3;
    logic [17:0]       LEDR;
    logic [45:0]       disp;

    logic              start_z = 1'b0, abort_z = 1'b0;
    logic [ADDR_W:0]   cmd_count_z = '0;
    logic [ADDR_W-1:0] rd_addr_z, cur_index_z;
    logic [1:0]        rd_data_z;
    logic              busy_z, done_z;
    logic [6:0]        HEX0_z, HEX1_z, HEX2_z, HEX3_z;
    logic [17:0]       LEDR_z;
    logic [45:0]       disp_z;

    logic [1:0] mem   [256];
    logic [1:0] mem_z [256];
    int tests = 0;
    int fails = 0;

    robot_cmd_player #(.ADDR_W(ADDR_W), .STEP_TICKS(4), .GAP_TICKS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cmd_count(cmd_count),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .cur_index(cur_index),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .LEDR(LEDR));

    robot_cmd_player #(.ADDR_W(ADDR_W), .STEP_TICKS(4), .GAP_TICKS(0)) dut_z (
        .clk(clk), .rst(rst), .start(start_z), .abort(abort_z), .cmd_count(cmd_count_z),
        .rd_addr(rd_addr_z), .rd_data(rd_data_z), .busy(busy_z), .done(done_z), .cur_index(cur_index_z),
        .HEX0(HEX0_z), .HEX1(HEX1_z), .HEX2(HEX2_z), .HEX3(HEX3_z), .LEDR(LEDR_z));

    assign disp   = {HEX3, HEX2, HEX1, HEX0, LEDR};
    assign disp_z = {HEX3_z, HEX2_z, HEX1_z, HEX0_z, LEDR_z};

    always #5 clk = ~clk;

    // 1-cycle-latency synchronous command memories
    always @(posedge clk) begin
        rd_data   <= mem[rd_addr];
        rd_data_z <= mem_z[rd_addr_z];
    end

    function automatic logic [45:0] exp_disp(input logic [1:0] c);
        case (c)
            2'b00:   return {7'h7F, 7'b0001110, 7'h7F, 7'h7F, 18'h00F0F};
            2'b01:   return {7'h7F, 7'h7F, 7'h7F, 7'b0101111, 18'h00F0C};
            2'b10:   return {7'h7F, 7'h7F, 7'b1000111, 7'h7F, 18'h00C0F};
            default: return {7'b0000011, 7'h7F, 7'h7F, 7'h7F, 18'h0F0F0};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        @(negedge clk);
        tests++;
        if ({busy, done} !== 2'b00 || disp !== BLANK || rd_addr !== '0 || cur_index !== '0) begin
            fails++;
            $display("FAIL reset_hold: busy=%b done=%b disp=%h rd_addr=%h cur=%h, want 0 0 %h 0 0",
                     busy, done, disp, rd_addr, cur_index, BLANK);
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        tests++;
        if ({busy, done, busy_z, done_z} !== 4'b0000 || disp !== BLANK || disp_z !== BLANK) begin
            fails++;
            $display("FAIL reset_release: busy=%b done=%b disp=%h disp_z=%h, want idle and blank",
                     busy, done, disp, disp_z);
        end
    endtask

    // Command j shows on cycles 2+8j..5+8j, blank for the next 4; the last one holds in DONE.
    task automatic test_playback();
        int j;
        logic [45:0] e;
        cmd_count = 9'd4;
        pulse_start();
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (k < 2) begin
                j = 0;
                e = BLANK;
            end else begin
                j = (k - 2) / 8;
                if (j >= 3) begin
                    j = 3;
                    e = exp_disp(2'b11);
                end else begin
                    e = (((k - 2) % 8) < 4) ? exp_disp(2'(j)) : BLANK;
                end
            end
            tests++;
            if (disp !== e) begin
                fails++;
                $display("FAIL play_disp cycle %0d: got %h want %h", k, disp, e);
            end
            tests++;
            if (busy !== (k < 30) || done !== (k >= 30) || cur_index !== 8'(j)) begin
                fails++;
                $display("FAIL play_status cycle %0d: busy=%b done=%b cur=%0d want %b %b %0d",
                         k, busy, done, cur_index, (k < 30), (k >= 30), j);
            end
            tick();
        end
    endtask

    task automatic test_zero_count();
        pulse_abort();
        @(negedge clk);
        tests++;
        if ({busy, done} !== 2'b00 || disp !== BLANK) begin
            fails++;
            $display("FAIL abort_from_done: busy=%b done=%b disp=%h want 0 0 blank", busy, done, disp);
        end
        cmd_count = '0;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if ({busy, done} !== 2'b01 || disp !== BLANK || rd_addr !== '0) begin
                fails++;
                $display("FAIL zero_count cycle %0d: busy=%b done=%b disp=%h rd_addr=%h want 0 1 blank 0",
                         k, busy, done, disp, rd_addr);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        cmd_count = 9'd3;
        pulse_start();
        repeat (11) tick();
        @(negedge clk);
        tests++;
        if (cur_index !== 8'd1 || disp !== exp_disp(2'b01) || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre: cur=%0d disp=%h busy=%b want 1 %h 1", cur_index, disp, busy, exp_disp(2'b01));
        end
        tick();
        pulse_abort();
        @(negedge clk);
        tests++;
        if ({busy, done} !== 2'b00 || disp !== BLANK) begin
            fails++;
            $display("FAIL abort_run: busy=%b done=%b disp=%h want 0 0 %h", busy, done, disp, BLANK);
        end
        pulse_start();
        repeat (2) tick();
        @(negedge clk);
        tests++;
        if (cur_index !== 8'd0 || disp !== exp_disp(2'b00) || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_replay: cur=%0d disp=%h busy=%b want 0 %h 1", cur_index, disp, busy, exp_disp(2'b00));
        end
    endtask

    task automatic test_start_abort();
        pulse_abort();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if ({busy, done} !== 2'b00 || disp !== BLANK) begin
                fails++;
                $display("FAIL start_abort cycle %0d: busy=%b done=%b disp=%h want 0 0 blank", k, busy, done, disp);
            end
            tick();
        end
        cmd_count = 9'd4;
        pulse_start();
        for (int k = 1; k < 32; k++) begin
            start = (k == 3 || k == 12 || k == 20);
            tick();
            start = 1'b0;
            @(negedge clk);
            if (k == 5 || k == 13 || k == 21 || k == 29) begin
                tests++;
                if (cur_index !== 8'((k - 5) / 8) || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL extra_start cycle %0d: cur=%0d busy=%b want %0d 1", k, cur_index, busy, (k - 5) / 8);
                end
            end
            if (k == 31) begin
                tests++;
                if ({busy, done} !== 2'b01 || cur_index !== 8'd3) begin
                    fails++;
                    $display("FAIL extra_start_done: busy=%b done=%b cur=%0d want 0 1 3", busy, done, cur_index);
                end
            end
        end
    endtask

    task automatic test_no_gap();
        logic [45:0] e;
        cmd_count_z = 9'd2;
        start_z = 1'b1;
        tick();
        start_z = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            e = (k < 2) ? BLANK : (k < 8) ? exp_disp(2'b11) : exp_disp(2'b00);
            tests++;
            if (disp_z !== e) begin
                fails++;
                $display("FAIL nogap_disp cycle %0d: got %h want %h", k, disp_z, e);
            end
            tests++;
            if (busy_z !== (k < 12) || done_z !== (k >= 12) || cur_index_z !== 8'(k >= 8)) begin
                fails++;
                $display("FAIL nogap_status cycle %0d: busy=%b done=%b cur=%0d want %b %b %0d",
                         k, busy_z, done_z, cur_index_z, (k < 12), (k >= 12), (k >= 8));
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        pulse_abort();
        cmd_count = 9'd4;
        pulse_start();
        repeat (11) tick();
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done} !== 2'b00 || disp !== BLANK || cur_index !== '0 || rd_addr !== '0) begin
            fails++;
            $display("FAIL async_reset: busy=%b done=%b disp=%h cur=%0d rd_addr=%0d want 0 0 blank 0 0",
                     busy, done, disp, cur_index, rd_addr);
        end
        tick();
        rst = 1'b0;
        tick();
        cmd_count = 9'd4;
        pulse_start();
        cmd_count = 9'd1;
        for (int k = 1; k < 31; k++) begin
            tick();
            @(negedge clk);
            if (k == 21 || k == 29) begin
                tests++;
                if (cur_index !== 8'((k - 5) / 8) || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL nreg_latch cycle %0d: cur=%0d busy=%b want %0d 1", k, cur_index, busy, (k - 5) / 8);
                end
            end
            if (k == 30) begin
                tests++;
                if ({busy, done} !== 2'b01 || disp !== exp_disp(2'b11)) begin
                    fails++;
                    $display("FAIL nreg_done: busy=%b done=%b disp=%h want 0 1 %h", busy, done, disp, exp_disp(2'b11));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 2'b00;
            mem_z[i] = 2'b00;
        end
        mem[0] = 2'b00; mem[1] = 2'b01; mem[2] = 2'b10; mem[3] = 2'b11;
        mem_z[0] = 2'b11; mem_z[1] = 2'b00;
        test_reset();
        test_playback();
        test_zero_count();
        test_abort();
        test_start_abort();
        test_no_gap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
